// File: rtl/stack_pkg.sv
// Shared definitions for the stack arbiter: FSM state encoding and push/pop opcodes.
package stack_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    POP_WAIT = 1'b1
  } state_e;

  localparam logic OP_POP  = 1'b0;
  localparam logic OP_PUSH = 1'b1;

endpackage

// File: rtl/stack_arbiter_if.sv
// Request/response bundle for the two stack requesters (A and B) plus the shared pop data.
interface stack_arbiter_if #(
  parameter int XLEN = 32
);

  logic            a_valid_i;
  logic            a_push_i;
  logic [XLEN-1:0] a_data_i;
  logic            a_ready_o;
  logic            a_resp_valid_o;

  logic            b_valid_i;
  logic            b_push_i;
  logic [XLEN-1:0] b_data_i;
  logic            b_ready_o;
  logic            b_resp_valid_o;

  logic [XLEN-1:0] resp_data_o;

  modport master (
    output a_valid_i, a_push_i, a_data_i,
    output b_valid_i, b_push_i, b_data_i,
    input  a_ready_o, a_resp_valid_o,
    input  b_ready_o, b_resp_valid_o,
    input  resp_data_o
  );

  modport slave (
    input  a_valid_i, a_push_i, a_data_i,
    input  b_valid_i, b_push_i, b_data_i,
    output a_ready_o, a_resp_valid_o,
    output b_ready_o, b_resp_valid_o,
    output resp_data_o
  );

endinterface

// File: rtl/bram.sv
// Single-port synchronous RAM: one shared address, write-enable, one-cycle registered read.
module bram #(
  parameter int XLEN = 32,
  parameter int SIZE = 7
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [SIZE-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem_q [2**SIZE];

  // NOTE: the array is deliberately never reset so it can map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/stack_arbiter.sv
// Two-requester round-robin arbiter in front of a BRAM-backed LIFO stack.
// Define STACK_ARBITER_HIGHWATER_EN to add the highwater_o depth watermark output.
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SIZE = 7
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            flush_i,
  input  logic            clear_err_i,
  output logic [SIZE:0]   depth_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            overflow_o,
  output logic            underflow_o,
`ifdef STACK_ARBITER_HIGHWATER_EN
  output logic [SIZE:0]   highwater_o,
`endif
  stack_arbiter_if.slave  req
);

  localparam logic [SIZE:0] DEPTH_MAX = (SIZE+1)'(2**SIZE);

  state_e          state_q, state_d;
  logic [SIZE:0]   depth_q, depth_d;
  logic            prio_b_q, prio_b_d;
  logic            resp_b_q, resp_b_d;
  logic            resp_zero_q, resp_zero_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic            grant_a, grant_b, accept;
  logic            op_push;
  logic [XLEN-1:0] op_data;
  logic            full, empty, resp_active;
  logic            ovf_set, unf_set;
  logic            we;
  logic [SIZE-1:0] addr;
  logic [XLEN-1:0] rdata;

  assign full   = (depth_q == DEPTH_MAX);
  assign empty  = (depth_q == '0);
  assign accept = grant_a | grant_b;

  // Requests are only served in IDLE, never under flush or reset; contention goes to prio_b_q's pick.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == IDLE && !flush_i && !reset_i) begin
      if (req.a_valid_i && req.b_valid_i) begin
        grant_a = !prio_b_q;
        grant_b = prio_b_q;
      end else begin
        grant_a = req.a_valid_i;
        grant_b = req.b_valid_i;
      end
    end
  end

  assign op_push = grant_b ? req.b_push_i : req.a_push_i;
  assign op_data = grant_b ? req.b_data_i : req.a_data_i;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    prio_b_d    = prio_b_q;
    resp_b_d    = resp_b_q;
    resp_zero_d = resp_zero_q;
    we          = 1'b0;
    addr        = depth_q[SIZE-1:0];
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          prio_b_d = grant_a;
          if (op_push == OP_PUSH) begin
            if (full) begin
              ovf_set = 1'b1;
            end else begin
              we      = 1'b1;
              depth_d = depth_q + (SIZE+1)'(1);
            end
          end else begin
            state_d  = POP_WAIT;
            resp_b_d = grant_b;
            if (empty) begin
              unf_set     = 1'b1;
              resp_zero_d = 1'b1;
            end else begin
              // Low bits wrap correctly when full: 2^SIZE - 1 == all ones.
              addr        = depth_q[SIZE-1:0] - SIZE'(1);
              depth_d     = depth_q - (SIZE+1)'(1);
              resp_zero_d = 1'b0;
            end
          end
        end
      end
      POP_WAIT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (flush_i) depth_d = '0;
  end

  // A clear coinciding with a new error leaves the flag set.
  assign ovf_d = ovf_set | (ovf_q & ~clear_err_i);
  assign unf_d = unf_set | (unf_q & ~clear_err_i);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      depth_q     <= '0;
      prio_b_q    <= 1'b0;
      resp_b_q    <= 1'b0;
      resp_zero_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      prio_b_q    <= prio_b_d;
      resp_b_q    <= resp_b_d;
      resp_zero_q <= resp_zero_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  bram #(
    .XLEN(XLEN),
    .SIZE(SIZE)
  ) u_bram (
    .clk_i  (clk_i),
    .we_i   (we),
    .addr_i (addr),
    .wdata_i(op_data),
    .rdata_o(rdata)
  );

`ifdef STACK_ARBITER_HIGHWATER_EN
  logic [SIZE:0] hw_q, hw_d;

  always_comb begin
    hw_d = hw_q;
    if (clear_err_i)                 hw_d = depth_d;
    else if (we && depth_d > hw_q)   hw_d = depth_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) hw_q <= '0;
    else         hw_q <= hw_d;
  end

  assign highwater_o = hw_q;
`endif

  // Reset asserted during POP_WAIT suppresses the pending response immediately.
  assign resp_active        = (state_q == POP_WAIT) && !reset_i;
  assign req.a_ready_o      = grant_a;
  assign req.b_ready_o      = grant_b;
  assign req.a_resp_valid_o = resp_active && !resp_b_q;
  assign req.b_resp_valid_o = resp_active && resp_b_q;
  assign req.resp_data_o    = (resp_active && !resp_zero_q) ? rdata : '0;

  assign depth_o     = depth_q;
  assign full_o      = full;
  assign empty_o     = empty;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule
